// File: rtl/regfile_write_demux_if.sv
// Writeback/clear bus between the pipeline writeback stage and regfile_write_demux.
// The dirty vector is present only when RF_DIRTY_TRACK_EN is defined.
interface regfile_write_demux_if #(
    parameter int N = 32
);
    logic           wr_valid;
    logic           wr_ready;
    logic [4:0]     wr_addr;
    logic [N-1:0]   wr_data;
    logic [31:0]    wr_onehot;
    logic           clr_req;
    logic           clr_busy;
    logic [32*N-1:0] rf_flat;
`ifdef RF_DIRTY_TRACK_EN
    logic [31:0]    dirty;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, wr_onehot, clr_busy, rf_flat, dirty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, wr_onehot, clr_busy, rf_flat, dirty
    );
`else
    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, wr_onehot, clr_busy, rf_flat
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, wr_onehot, clr_busy, rf_flat
    );
`endif
endinterface

// File: rtl/regfile_write_demux.sv
// Write side of the 32 x N register file: rd decode, x0 hardwired to zero, and a
// one-register-per-cycle bulk clear of x1..x31. Optional dirty flags: RF_DIRTY_TRACK_EN.
module regfile_write_demux #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_demux_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]    state;
    logic [4:0]    clr_cnt;
    logic [N-1:0]  regs [1:31];
    logic          accept;
    logic [31:0]   wr_hot;
    logic [31:1]   clr_hot;
    logic [32*N-1:0] rf_flat_d;

    assign bus.wr_ready = (state == IDLE);
    assign bus.clr_busy = (state == CLEAR);
    assign accept       = bus.wr_valid && bus.wr_ready;

    // A write to x0 still completes the handshake but never raises a strobe.
    always_comb begin
        wr_hot = '0;
        if (accept && (bus.wr_addr != 5'd0))
            wr_hot = 32'd1 << bus.wr_addr;
    end

    assign bus.wr_onehot = wr_hot;

    always_comb begin
        clr_hot = '0;
        for (int i = 1; i < 32; i++)
            clr_hot[i] = (state == CLEAR) && (clr_cnt == 5'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= 5'd1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 5'd1;
                    if (clr_cnt == 5'd31)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes and sweep strobes are mutually exclusive since wr_ready is low in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (clr_hot[i])
                    regs[i] <= '0;
                else if (wr_hot[i])
                    regs[i] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        rf_flat_d = '0;
        for (int i = 1; i < 32; i++)
            rf_flat_d[i*N +: N] = regs[i];
    end

    assign bus.rf_flat = rf_flat_d;

`ifdef RF_DIRTY_TRACK_EN
    logic [31:1] dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (clr_hot[i])
                    dirty_q[i] <= 1'b0;
                else if (wr_hot[i])
                    dirty_q[i] <= 1'b1;
            end
        end
    end

    assign bus.dirty = {dirty_q, 1'b0};
`endif

endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed self-checking bench for regfile_write_demux (N=32); the dirty-flag
// scenario is compiled in when RF_DIRTY_TRACK_EN is defined.
module tb_regfile_write_demux;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [N-1:0] model [32];

    always #5 clk = ~clk;

    regfile_write_demux_if #(.N(N)) bus ();

    regfile_write_demux #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [N-1:0] field(input int i);
        return bus.rf_flat[i*N +: N];
    endfunction

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic model_clear;
        for (int i = 0; i < 32; i++)
            model[i] = '0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [N-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
        if (a != 5'd0)
            model[a] = d;
    endtask

    task automatic test_reset;
        int errs;
        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.rf_flat !== '0) begin
            bad++;
            $display("[TB] FAIL reset_rf: rf_flat nonzero after initial reset");
        end
        write_reg(5'd12, 32'hCAFE_0012);
        total++;
        if (field(12) !== 32'hCAFE_0012) begin
            bad++;
            $display("[TB] FAIL pre_reset_write: x12 got %h want %h", field(12), 32'hCAFE_0012);
        end
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        rst_n = 1'b0;
        #1;
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (field(i) !== '0) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL reset_midop_rf: %0d fields nonzero during reset, want 0", errs);
        end
        total++;
        if (bus.clr_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_midop_busy: clr_busy got %b want 0", bus.clr_busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
        total++;
        if (bus.wr_ready !== 1'b1 || bus.clr_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: ready=%b busy=%b want ready=1 busy=0",
                     bus.wr_ready, bus.clr_busy);
        end
    endtask

    task automatic test_write;
        int errs;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 32'hA5A5_A5A5;
        #1;
        total++;
        if (bus.wr_onehot !== 32'h0000_0020) begin
            bad++;
            $display("[TB] FAIL write_onehot: got %h want %h", bus.wr_onehot, 32'h0000_0020);
        end
        total++;
        if (field(5) !== 32'h0) begin
            bad++;
            $display("[TB] FAIL write_latency: x5 got %h before edge, want 0", field(5));
        end
        tick();
        bus.wr_valid = 1'b0;
        model[5] = 32'hA5A5_A5A5;
        total++;
        if (field(5) !== 32'hA5A5_A5A5) begin
            bad++;
            $display("[TB] FAIL write_data: x5 got %h want %h", field(5), 32'hA5A5_A5A5);
        end
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (field(i) !== model[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL write_others: %0d fields differ, want 0", errs);
        end
    endtask

    task automatic test_write_x0;
        int errs;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'hFFFF_FFFF;
        #1;
        total++;
        if (bus.wr_ready !== 1'b1 || bus.wr_onehot !== 32'h0) begin
            bad++;
            $display("[TB] FAIL x0_handshake: ready=%b onehot=%h want ready=1 onehot=0",
                     bus.wr_ready, bus.wr_onehot);
        end
        tick();
        bus.wr_valid = 1'b0;
        total++;
        if (field(0) !== 32'h0) begin
            bad++;
            $display("[TB] FAIL x0_field: got %h want 0", field(0));
        end
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (field(i) !== model[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL x0_others: %0d fields differ, want 0", errs);
        end
    endtask

    task automatic test_sweep;
        int busy_cycles;
        int stall_errs;
        int order_errs;
        int errs;
        logic [N-1:0] exp;
        for (int i = 1; i < 32; i++)
            write_reg(5'(i), N'(i));
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (field(i) !== model[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL fill: %0d fields differ, want 0", errs);
        end
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd7;
        bus.wr_data  = 32'h0000_0077;
        busy_cycles = 0;
        stall_errs  = 0;
        order_errs  = 0;
        for (int k = 0; k < 40 && bus.clr_busy === 1'b1; k++) begin
            busy_cycles++;
            if (bus.wr_ready !== 1'b0 || bus.wr_onehot !== 32'h0) stall_errs++;
            for (int j = 1; j < 32; j++) begin
                exp = (j < busy_cycles) ? '0 : N'(j);
                if (field(j) !== exp) order_errs++;
            end
            tick();
        end
        total++;
        if (busy_cycles != 31) begin
            bad++;
            $display("[TB] FAIL sweep_len: busy for %0d cycles, want 31", busy_cycles);
        end
        total++;
        if (stall_errs != 0) begin
            bad++;
            $display("[TB] FAIL sweep_stall: %0d cycles with ready/onehot active, want 0", stall_errs);
        end
        total++;
        if (order_errs != 0) begin
            bad++;
            $display("[TB] FAIL sweep_order: %0d field errors during sweep, want 0", order_errs);
        end
        total++;
        if (bus.wr_ready !== 1'b1 || bus.wr_onehot !== 32'h0000_0080) begin
            bad++;
            $display("[TB] FAIL held_write_accept: ready=%b onehot=%h want ready=1 onehot=00000080",
                     bus.wr_ready, bus.wr_onehot);
        end
        tick();
        bus.wr_valid = 1'b0;
        model_clear();
        model[7] = 32'h0000_0077;
        errs = 0;
        for (int i = 0; i < 32; i++)
            if (field(i) !== model[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL after_sweep: %0d fields differ, want 0 (x7=%h)", errs, field(7));
        end
    endtask

    task automatic test_simultaneous;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 5'd9;
        bus.wr_data  = 32'h0000_1234;
        bus.clr_req  = 1'b1;
        #1;
        total++;
        if (bus.wr_onehot !== 32'h0000_0200) begin
            bad++;
            $display("[TB] FAIL simul_onehot: got %h want 00000200", bus.wr_onehot);
        end
        tick();
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        total++;
        if (field(9) !== 32'h0000_1234 || bus.clr_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL simul_write: x9=%h busy=%b want x9=00001234 busy=1",
                     field(9), bus.clr_busy);
        end
        for (int k = 0; k < 40 && bus.clr_busy === 1'b1; k++)
            tick();
        total++;
        if (bus.clr_busy !== 1'b0 || bus.rf_flat !== '0) begin
            bad++;
            $display("[TB] FAIL simul_cleared: busy=%b x9=%h x7=%h want busy=0 all zero",
                     bus.clr_busy, field(9), field(7));
        end
        model_clear();
        write_reg(5'd4, 32'h0000_0044);
        write_reg(5'd20, 32'h0000_2020);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (9) tick();
        total++;
        if (field(20) !== 32'h0000_2020 || field(4) !== 32'h0) begin
            bad++;
            $display("[TB] FAIL sweep_cycle10: x4=%h x20=%h want x4=0 x20=00002020",
                     field(4), field(20));
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.rf_flat !== '0 || bus.clr_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_reset: x20=%h busy=%b want 0 and 0", field(20), bus.clr_busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
        total++;
        if (bus.wr_ready !== 1'b1 || bus.clr_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_release: ready=%b busy=%b want 1 and 0",
                     bus.wr_ready, bus.clr_busy);
        end
    endtask

`ifdef RF_DIRTY_TRACK_EN
    task automatic test_dirty;
        total++;
        if (bus.dirty !== 32'h0) begin
            bad++;
            $display("[TB] FAIL dirty_reset: got %h want 0", bus.dirty);
        end
        write_reg(5'd3, 32'h0000_0003);
        write_reg(5'd31, 32'h0000_001F);
        write_reg(5'd0, 32'hFFFF_FFFF);
        total++;
        if (bus.dirty !== 32'h8000_0008) begin
            bad++;
            $display("[TB] FAIL dirty_set: got %h want 80000008", bus.dirty);
        end
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 40 && bus.clr_busy === 1'b1; k++)
            tick();
        total++;
        if (bus.dirty !== 32'h0 || bus.clr_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dirty_sweep: dirty=%h busy=%b want 0 and 0", bus.dirty, bus.clr_busy);
        end
        model_clear();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_write_x0();
        test_sweep();
        test_simultaneous();
`ifdef RF_DIRTY_TRACK_EN
        test_dirty();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
